// File: rtl/demux4_router_pkg.sv
// Shared definitions for the 4-way router: select encodings, default widths,
// and the per-channel slot state encoding.
package demux4_router_pkg;

  // Select value {s1,s0} that steers a word to each channel
  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  // Default data word width and delivery counter width
  localparam int DEF_W  = 32;
  localparam int DEF_CW = 8;

  // One-entry slot occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux4_router_slot.sv
// demux_slot: one output channel of the router. Holds a single word with a
// two-state EMPTY/FULL FSM. The delivery counter is built only when
// DEMUX4_ROUTER_CNT_EN is defined.
//
// Handshake: a word moves across an interface on a rising clk edge exactly when
// its valid and ready are both 1; valid never waits for ready, and the data
// held behind a raised valid does not change until that transfer happens.
module demux_slot
  import demux4_router_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         acc,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         vld,
  output slot_state_t  state
`ifdef DEMUX4_ROUTER_CNT_EN
  ,
  output logic [CW-1:0] cnt
`endif
);

  if (CW < 1) begin : g_bad_cw
    $error("demux_slot: CW must be at least 1");
  end

  slot_state_t state_q;
  slot_state_t state_d;
  logic        drain;

  // The slot is FULL exactly when its valid is up, so vld comes straight from the state flop
  assign vld   = (state_q == FULL);
  assign state = state_q;
  assign drain = vld & rdy;

  // Next-state: fill on accept, empty on a drain that is not refilled in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (acc) state_d = FULL;
      FULL:    if (drain && !acc) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Data register: loads on accept only, so it keeps its value after draining
  always_ff @(posedge clk) begin
    if (!rst_n)   dout <= '0;
    else if (acc) dout <= din;
  end

`ifdef DEMUX4_ROUTER_CNT_EN
  // Delivery counter: one count per drain, wrapping naturally at 2^CW
  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= '0;
    else if (drain) cnt <= cnt + CW'(1);
  end
`endif

endmodule

// File: rtl/demux4_router.sv
// demux4_router: routes one input word to one of four single-entry output
// channels chosen by {s1,s0}. Each channel is a demux_slot; this level only
// decodes the select and forms in_ready. Optional per-channel delivery
// counters are enabled with the macro DEMUX4_ROUTER_CNT_EN.
//
// Handshake: in_valid/in_ready and vk/rk all transfer on a rising clk edge
// when valid and ready are both 1. in_ready depends only on the selected slot
// and its sink ready, never on in_valid.
module demux4_router
  import demux4_router_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         s0,
  input  logic         s1,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         r0,
  input  logic         r1,
  input  logic         r2,
  input  logic         r3
`ifdef DEMUX4_ROUTER_CNT_EN
  ,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
`endif
);

  logic [1:0]   sel;
  logic [3:0]   acc;
  logic [3:0]   rdy;
  logic [3:0]   vld;
  logic [W-1:0] dout [4];
  slot_state_t  st [4];
`ifdef DEMUX4_ROUTER_CNT_EN
  logic [CW-1:0] cnt [4];
`endif

  assign sel = {s1, s0};
  assign rdy = {r3, r2, r1, r0};

  // in_ready: selected slot can take a word now (empty, or full and draining); never during reset
  always_comb begin
    in_ready = 1'b0;
    case (sel)
      SEL_CH0: in_ready = (st[0] == EMPTY) | rdy[0];
      SEL_CH1: in_ready = (st[1] == EMPTY) | rdy[1];
      SEL_CH2: in_ready = (st[2] == EMPTY) | rdy[2];
      SEL_CH3: in_ready = (st[3] == EMPTY) | rdy[3];
      default: in_ready = 1'b0;
    endcase
    if (!rst_n) in_ready = 1'b0;
  end

  // Accept decode: one-hot write enable for the selected slot on a completed input handshake
  always_comb begin
    acc = 4'b0000;
    if (in_valid && in_ready) begin
      case (sel)
        SEL_CH0: acc = 4'b0001;
        SEL_CH1: acc = 4'b0010;
        SEL_CH2: acc = 4'b0100;
        SEL_CH3: acc = 4'b1000;
        default: acc = 4'b0000;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(.W(W), .CW(CW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (acc[k]),
      .din   (in_data),
      .rdy   (rdy[k]),
      .dout  (dout[k]),
      .vld   (vld[k]),
      .state (st[k])
`ifdef DEMUX4_ROUTER_CNT_EN
      ,
      .cnt   (cnt[k])
`endif
    );
  end

  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];
  assign v0   = vld[0];
  assign v1   = vld[1];
  assign v2   = vld[2];
  assign v3   = vld[3];

`ifdef DEMUX4_ROUTER_CNT_EN
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Directed bench for demux4_router. Inputs change 1 time unit after a rising
// edge; registered outputs are checked there, combinational in_ready 1 unit
// later. Counter checks are compiled in with DEMUX4_ROUTER_CNT_EN.
module tb_demux4_router;
  localparam int W  = 32;
  localparam int CW = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         s0, s1;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0, out1, out2, out3;
  logic         v0, v1, v2, v3;
  logic         r0, r1, r2, r3;
`ifdef DEMUX4_ROUTER_CNT_EN
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  demux4_router #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .s0       (s0),
    .s1       (s1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .v0       (v0),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3)
`ifdef DEMUX4_ROUTER_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [W-1:0] d);
    in_valid = vld;
    {s1, s0} = sel;
    in_data  = d;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {r3, r2, r1, r0} = r;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, {63'd0, in_ready}, {63'd0, exp});
  endtask

  task automatic check_v(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, v3, v2, v1, v0}, {60'd0, exp});
  endtask

`ifdef DEMUX4_ROUTER_CNT_EN
  task automatic check_cnt(input string tag, input logic [CW-1:0] e0, input logic [CW-1:0] e1,
                           input logic [CW-1:0] e2, input logic [CW-1:0] e3);
    check({tag, "_cnt0"}, 64'(cnt0), 64'(e0));
    check({tag, "_cnt1"}, 64'(cnt1), 64'(e1));
    check({tag, "_cnt2"}, 64'(cnt2), 64'(e2));
    check({tag, "_cnt3"}, 64'(cnt3), 64'(e3));
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0);
    set_ready(4'b0000);
    #1;

    // ---- reset / idle ----
    check_ready("rst_in_ready_low", 1'b0);
    step();
    step();
    check_v("rst_v", 4'b0000);
    check("rst_out0", 64'(out0), 64'd0);
    check("rst_out1", 64'(out1), 64'd0);
    check("rst_out2", 64'(out2), 64'd0);
    check("rst_out3", 64'(out3), 64'd0);
`ifdef DEMUX4_ROUTER_CNT_EN
    check_cnt("rst", 8'd0, 8'd0, 8'd0, 8'd0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'(k), '0);
      check_ready($sformatf("idle_in_ready_sel%0d", k), 1'b1);
    end

    // ---- basic routing, first accept on the first edge out of reset ----
    set_ready(4'b1111);
    drive(1'b1, 2'b00, 32'hA0);
    step();
    check_v("route_v_a", 4'b0001);
    check("route_out0", 64'(out0), 64'hA0);
    drive(1'b1, 2'b01, 32'hB1);
    step();
    check_v("route_v_b", 4'b0010);
    check("route_out1", 64'(out1), 64'hB1);
    check("route_out0_kept", 64'(out0), 64'hA0);
    drive(1'b1, 2'b10, 32'hC2);
    step();
    check_v("route_v_c", 4'b0100);
    check("route_out2", 64'(out2), 64'hC2);
    drive(1'b1, 2'b11, 32'hD3);
    step();
    check_v("route_v_d", 4'b1000);
    check("route_out3", 64'(out3), 64'hD3);
    drive(1'b0, 2'b00, '0);
    step();
    check_v("route_v_idle", 4'b0000);
    check("route_out3_kept", 64'(out3), 64'hD3);

    // ---- backpressure on channel 2 ----
    set_ready(4'b1011);
    drive(1'b1, 2'b10, 32'h11);
    check_ready("bp_rdy_11", 1'b1);
    step();
    check_v("bp_v_11", 4'b0100);
    check("bp_out2_11", 64'(out2), 64'h11);
    drive(1'b1, 2'b10, 32'h22);
    check_ready("bp_rdy_22_blocked", 1'b0);
    step();
    check_v("bp_v_stall", 4'b0100);
    check("bp_out2_hold", 64'(out2), 64'h11);
    drive(1'b1, 2'b00, 32'h33);
    check_ready("bp_rdy_33_other", 1'b1);
    step();
    check_v("bp_v_33", 4'b0101);
    check("bp_out0_33", 64'(out0), 64'h33);
    check("bp_out2_hold2", 64'(out2), 64'h11);
    set_ready(4'b1111);
    drive(1'b1, 2'b10, 32'h22);
    check_ready("bp_rdy_22_release", 1'b1);
    step();
    check_v("bp_v_22", 4'b0100);
    check("bp_out2_22", 64'(out2), 64'h22);
    drive(1'b0, 2'b00, '0);
    step();
    check_v("bp_v_idle", 4'b0000);

    // ---- streaming 16 words on channel 1 ----
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b01, 32'(i));
      check_ready($sformatf("stream_rdy_%0d", i), 1'b1);
      step();
      check_v($sformatf("stream_v_%0d", i), 4'b0010);
      check($sformatf("stream_out1_%0d", i), 64'(out1), 64'(i));
    end
    drive(1'b0, 2'b00, '0);
    step();
    check_v("stream_v_idle", 4'b0000);
`ifdef DEMUX4_ROUTER_CNT_EN
    check_cnt("after_stream", 8'd2, 8'd17, 8'd3, 8'd1);
`endif

    // ---- reset mid-operation with channels 0 and 3 full ----
    set_ready(4'b0000);
    drive(1'b1, 2'b00, 32'h55);
    step();
    drive(1'b1, 2'b11, 32'h66);
    step();
    check_v("mid_v_full", 4'b1001);
    check("mid_out0", 64'(out0), 64'h55);
    check("mid_out3", 64'(out3), 64'h66);
    drive(1'b0, 2'b11, '0);
    rst_n = 1'b0;
    check_ready("mid_rdy_in_reset", 1'b0);
    step();
    check_v("mid_v_after_rst", 4'b0000);
    check("mid_out0_cleared", 64'(out0), 64'd0);
    check("mid_out3_cleared", 64'(out3), 64'd0);
`ifdef DEMUX4_ROUTER_CNT_EN
    check_cnt("mid_rst", 8'd0, 8'd0, 8'd0, 8'd0);
`endif
    rst_n = 1'b1;
    set_ready(4'b1111);
    step();
    step();
    check_v("mid_no_replay", 4'b0000);
    check("mid_out0_still0", 64'(out0), 64'd0);
    check("mid_out3_still0", 64'(out3), 64'd0);

    // ---- 257 deliveries on channel 3 (counter wrap) ----
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 2'b11, 32'(i + 32'h1000));
      step();
    end
    check_v("wrap_v_last", 4'b1000);
    check("wrap_out3_last", 64'(out3), 64'h1101);
`ifdef DEMUX4_ROUTER_CNT_EN
    check_cnt("wrap_256", 8'd0, 8'd0, 8'd0, 8'd0);
`endif
    drive(1'b0, 2'b00, '0);
    step();
    check_v("wrap_v_idle", 4'b0000);
`ifdef DEMUX4_ROUTER_CNT_EN
    check_cnt("wrap_257", 8'd0, 8'd0, 8'd0, 8'd1);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux4_router.md
DEMUX4_ROUTER -- requirements
Module: demux4_router

Interface
REQ-001 SHALL have parameter W, default 32, data word width.
REQ-002 SHALL have parameter CW, default 8, delivery counter width.
REQ-003 SHALL have ports, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  W  word to route.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- in_valid  input  1  source offers in_data/s1:s0.
- in_ready  output  1  router accepts this cycle.
- out0..out3  output  W  per-channel data.
- v0..v3  output  1  per-channel valid.
- r0..r3  input  1  per-channel sink ready.
- cnt0..cnt3  output  CW  per-channel delivery count; present only under REQ-016.

Function
REQ-004 SHALL route in_data to channel k = {s1,s0}: 00->0, 01->1, 10->2, 11->3.
- This is the inverse of the team's 4:1 mux select mapping.
REQ-005 SHALL give each channel a one-entry slot as a two-state FSM:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on drain without same-cycle accept.
- FULL -> FULL on drain with same-cycle accept.
- Otherwise hold.
REQ-006 SHALL drive in_ready combinationally as (slot k EMPTY) or (slot k FULL and rk=1).
- k is the current {s1,s0}.
- in_ready shall not depend on in_valid.
REQ-007 SHALL accept when in_valid=1 and in_ready=1, writing in_data into slot k at that clk edge.
REQ-008 SHALL assert vk and present outk from the cycle after accept (latency 1); outk and vk SHALL be register outputs.
REQ-009 SHALL drain slot k when vk=1 and rk=1 at a clk edge.
REQ-010 SHALL hold outk stable while vk=1 and rk=0.
REQ-011 SHALL let simultaneous accept and drain on the same channel load the new word with vk staying 1 (full throughput, no bubble).
REQ-012 SHALL let accept on channel k and drains on other channels occur in the same cycle independently.
REQ-013 SHALL make a stalled channel block only inputs selecting that channel; other channels still accept.
REQ-014 SHALL leave outk unchanged when slot k goes EMPTY; only vk falls.

Reset
REQ-015 SHALL, at a clk edge with rst_n=0:
- Force all slots EMPTY, v0..v3=0, out0..out3=0, cnt0..cnt3=0.
- Drop any in-flight word.
- Hold in_ready=0 while rst_n=0, so no accept occurs in a reset cycle.
- Allow the first accept on the first edge with rst_n=1.

Configuration
REQ-016 SHALL compile the counters in only when macro DEMUX4_ROUTER_CNT_EN is defined:
- cntk increments by 1 on each drain of channel k.
- cntk wraps from 2^CW-1 to 0.
- cntk is reset per REQ-015.
- Without the macro, there are no cnt ports, no counter registers, and all other behaviour is identical.

Structure
REQ-017 SHALL place the following in shared package demux4_router_pkg:
- Select encoding constants SEL_CH0..SEL_CH3.
- Default W=32 and CW=8.
- Slot state encoding EMPTY=0, FULL=1.
REQ-018 SHALL implement each channel as four instances of sub-module demux_slot.
- demux_slot holds the FSM, data register and optional counter.
- The top holds select decode and the in_ready mux.

Verification
REQ-019 SHALL cover the following directed scenarios:
- Reset/idle: rst_n=0 for 2 cycles, then 1 -> v0..v3=0, out*=0, cnt*=0; in_ready=1 for every select in first post-reset cycle.
- Basic routing: r*=1; send 0xA0 sel 00, 0xB1 sel 01, 0xC2 sel 10, 0xD3 sel 11 on consecutive cycles -> each appears on out0..out3 with vk=1 exactly one cycle after its accept, one cycle wide.
- Backpressure: r2=0; send 0x11 then 0x22 to sel 10.
  - 0x11 accepted; in_ready=0 for 0x22; out2 holds 0x11.
  - Meanwhile 0x33 to sel 00 is accepted.
  - Raise r2 -> 0x11 drains, 0x22 accepted the same cycle, v2 stays 1, out2=0x22 next cycle.
- Streaming: r1=1; 16 back-to-back words 0..15 to sel 01 -> in_ready=1 every cycle, out1 sequence 0..15 with no gaps.
- Reset mid-operation: slots 0 and 3 FULL with r*=0; assert rst_n=0 one cycle -> v0=v3=0, out0=out3=0; the dropped words never appear.
- Counter wrap (DEMUX4_ROUTER_CNT_EN, CW=8): 257 drains on channel 3 -> cnt3=1; cnt0..cnt2=0. Without the macro, the same bench minus cnt checks passes.
